// File: rtl/uart_debug_rx.sv
// -----------------------------------------------------------------------------
// uart_debug_rx
//
// Receive-only 8N1 UART for the debug link. It samples the host serial line at
// CLKS_PER_BIT clk_50 cycles per bit (218 by default, about 229.4 kbaud). Each
// good byte is handed to the consumer through a one-entry valid/ready holding
// register. Glitches on the start bit are ignored silently. Framing errors,
// overruns and, optionally, parity errors are reported as 1-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frame = start + 8 data + parity + stop. PARITY_ODD selects odd
//               (1) or even (0) parity. A byte with bad parity is discarded.
//   undefined : plain 8N1. rx_parity_err is tied to 0.
//
// Parameters
//   CLKS_PER_BIT  clk_50 cycles per bit, 16..1023
//   HALF_BIT      cycles from the synchronised start edge to the start-bit centre
//   PARITY_ODD    parity sense; this parameter exists only with UART_RX_PARITY_EN
//
// Ports
//   clk_50         in   system clock, 50 MHz
//   reset          in   synchronous, active-high
//   uart_rx        in   asynchronous serial input, idles high
//   rx_data        out  received byte, stable while rx_valid=1
//   rx_valid       out  holding register full
//   rx_ready       in   consumer takes the byte when rx_valid && rx_ready
//   rx_frame_err   out  pulse: stop bit sampled 0
//   rx_overrun     out  pulse: byte completed while the holding register was full
//   rx_parity_err  out  pulse: parity mismatch (constant 0 without the macro)
// -----------------------------------------------------------------------------
module uart_debug_rx #(
    parameter int CLKS_PER_BIT = 218,
    parameter int HALF_BIT     = 109
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_LAST = 10'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    logic       rx_meta_q;
    logic       rx_s_q;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [7:0] shift_q, shift_d;
    logic       stop_sample;

    // Stop-bit result held for one cycle; the delivery decision is made the
    // cycle after the stop sample.
    logic       done_q;
    logic       stop_bit_q;
    logic       par_bad;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       deliver;

    logic       bit_end;
    logic       half_end;

`ifdef UART_RX_PARITY_EN
    logic       par_bit_q, par_bit_d;
    logic       parity_err_q, parity_err_d;
`endif

    assign bit_end  = (cnt_q == BIT_LAST);
    assign half_end = (cnt_q == HALF_LAST);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s_q) state_d = S_START;
            // A start bit that is already high again at its centre was a glitch.
            S_START: if (half_end) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_end && (bidx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            // Leaving at mid-stop-bit lets the next start edge follow immediately.
            S_STOP:  if (bit_end) state_d = rx_s_q ? S_IDLE : S_BREAK;
            // A line held low reports one framing error, then waits for idle.
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        cnt_d       = cnt_q + 10'd1;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
`endif
        case (state_q)
            S_IDLE, S_BREAK: cnt_d = '0;
            S_START: begin
                if (half_end && !rx_s_q) bidx_d = '0;
            end
            S_DATA: begin
                // The counter restarts at every data bit, because DATA spans 8 bits.
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (bit_end) par_bit_d = rx_s_q;
`endif
            S_STOP: if (bit_end) stop_sample = 1'b1;
            default: ;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // ---------------------------------------------------------------- delivery
`ifdef UART_RX_PARITY_EN
    assign par_bad = (((^shift_q) ^ par_bit_q) != PARITY_ODD);
`else
    assign par_bad = 1'b0;
`endif

    assign deliver = done_q && stop_bit_q && !par_bad;

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = done_q && !stop_bit_q;
        if (valid_q && rx_ready) valid_d = 1'b0;
        if (deliver) begin
            // A same-cycle handshake frees the register for the new byte.
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // A bad stop bit takes precedence; only the framing error is reported.
    assign parity_err_d = done_q && stop_bit_q && par_bad;
`endif

    always_ff @(posedge clk_50) begin
        if (reset) begin
            done_q      <= 1'b0;
            stop_bit_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            done_q <= stop_sample;
            if (stop_sample) stop_bit_q <= rx_s_q;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
